mod_exp_engine: RTL and testbench

MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

---
 rtl/mod_exp_engine.sv | 139 +++++++++++++
 tb/tb_mod_exp_engine.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_engine.sv
// rtl/mod_exp_engine.sv - modular exponentiation engine, right-to-left binary square-and-multiply
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       synchronous reset, active high; aborts any in-flight operation
//   start     request pulse, only looked at in IDLE, never queued
//   base      base operand (WIDTH bits)
//   exponent  exponent operand, unsigned (WIDTH bits)
//   modulus   modulus operand, unsigned (WIDTH bits)
//   busy      high from the cycle after acceptance until the done cycle
//   done      one-cycle completion pulse
//   err       raised together with done when the latched modulus was zero
//   result    (base^exponent) mod modulus, held until the next done
//
// Latency is fixed at 2*WIDTH+3 cycles from the start cycle to done: every
// exponent bit costs one MUL and one SQR cycle, whether the bit is set or not.
// A zero modulus shortcuts LOAD -> FIN and completes after 3 cycles.

module mod_exp_engine #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL  = 3'd2,
        SQR  = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;     // running product
    logic [WIDTH-1:0] b;       // base, squared once per exponent bit
    logic [WIDTH-1:0] e;       // exponent, shifted right once per bit
    logic [WIDTH-1:0] mod_q;   // latched modulus
    logic [CW-1:0]    cnt;     // exponent bits consumed so far

    // The divisor is forced to 1 when the modulus is zero so the reduction
    // logic never divides by zero; the zero-modulus path skips MUL/SQR and
    // discards whatever these reductions produce.
    logic [WIDTH-1:0]   mod_div;
    logic [2*WIDTH-1:0] mod_ext;
    logic [2*WIDTH-1:0] prod_mul;
    logic [2*WIDTH-1:0] prod_sqr;

    // Both products are formed at full double width before reduction, so the
    // remainder is exact for every operand value.
    assign mod_div  = (mod_q == '0) ? WIDTH'(1) : mod_q;
    assign mod_ext  = {{WIDTH{1'b0}}, mod_div};
    assign prod_mul = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, b};
    assign prod_sqr = {{WIDTH{1'b0}}, b} * {{WIDTH{1'b0}}, b};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            b      <= '0;
            e      <= '0;
            mod_q  <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            // done is a single-cycle pulse; only FIN raises it.
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        // Operands are captured here; later input changes
                        // cannot disturb the operation.
                        b     <= base;
                        e     <= exponent;
                        mod_q <= modulus;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    // 1 mod m is 0 only for m == 1; m == 0 is handled in FIN.
                    acc   <= (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    b     <= b % mod_div;
                    cnt   <= '0;
                    state <= (mod_q == '0) ? FIN : MUL;
                end

                MUL: begin
                    if (e[0]) begin
                        acc <= WIDTH'(prod_mul % mod_ext);
                    end
                    state <= SQR;
                end

                SQR: begin
                    b     <= WIDTH'(prod_sqr % mod_ext);
                    e     <= e >> 1;
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == LAST_BIT) ? FIN : MUL;
                end

                FIN: begin
                    if (mod_q == '0) begin
                        result <= '0;
                        err    <= 1'b1;
                    end else begin
                        result <= acc;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_engine.sv
// tb/tb_mod_exp_engine.sv - self-checking bench for mod_exp_engine at WIDTH 32, 16 and 64

module tb_mod_exp_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic        s32 = 1'b0;
    logic [31:0] b32 = '0, e32 = '0, m32 = '0, r32;
    logic        busy32, done32, err32;

    logic        s16 = 1'b0;
    logic [15:0] b16 = '0, e16 = '0, m16 = '0, r16;
    logic        busy16, done16, err16;

    logic        s64 = 1'b0;
    logic [63:0] b64 = '0, e64 = '0, m64 = '0, r64;
    logic        busy64, done64, err64;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    mod_exp_engine #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .start(s32), .base(b32), .exponent(e32), .modulus(m32),
        .busy(busy32), .done(done32), .err(err32), .result(r32)
    );

    mod_exp_engine #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(s16), .base(b16), .exponent(e16), .modulus(m16),
        .busy(busy16), .done(done16), .err(err16), .result(r16)
    );

    mod_exp_engine #(.WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .start(s64), .base(b64), .exponent(e64), .modulus(m64),
        .busy(busy64), .done(done64), .err(err64), .result(r64)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: left-to-right exponentiation on wide integers, zero modulus gives 0.
    function automatic logic [63:0] ref_pow(input logic [63:0] b, input logic [63:0] e,
                                            input logic [63:0] m, input int w);
        logic [127:0] r;
        logic [127:0] mm;
        if (m == 64'd0) return 64'd0;
        mm = {64'd0, m};
        r  = 128'd1 % mm;
        for (int i = w - 1; i >= 0; i--) begin
            r = (r * r) % mm;
            if (e[i]) r = (r * {64'd0, b}) % mm;
        end
        return r[63:0];
    endfunction

    // Starts an operation at the current negedge and follows it to done.
    // Inputs are scrambled after acceptance to show they are latched.
    task automatic run32(input string tag, input logic [31:0] b, input logic [31:0] e,
                         input logic [31:0] m, input logic [31:0] exp_res,
                         input logic exp_err, input int exp_lat);
        int   lat;
        logic busy1;
        logic err1;
        s32 = 1'b1; b32 = b; e32 = e; m32 = m;
        lat = 0; busy1 = 1'b0; err1 = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            s32 = 1'b0; b32 = $urandom; e32 = $urandom; m32 = $urandom;
            if (lat == 1) begin
                busy1 = busy32;
                err1  = err32;
            end
        end while (!done32 && lat < 300);
        check({tag, "_lat"},      128'(lat),    128'(exp_lat));
        check({tag, "_res"},      128'(r32),    128'(exp_res));
        check({tag, "_err"},      128'(err32),  128'(exp_err));
        check({tag, "_busy1"},    128'(busy1),  128'(1'b1));
        check({tag, "_errclr"},   128'(err1),   128'(1'b0));
        check({tag, "_busydone"}, 128'(busy32), 128'(1'b0));
    endtask

    task automatic rnd16(input int n);
        logic [15:0] b, e, m;
        int lat;
        for (int i = 0; i < n; i++) begin
            b = 16'($urandom); e = 16'($urandom); m = 16'($urandom);
            if (i % 8 == 0) m = 16'($urandom_range(0, 15));
            s16 = 1'b1; b16 = b; e16 = e; m16 = m;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
                s16 = 1'b0; b16 = 16'($urandom); e16 = 16'($urandom); m16 = 16'($urandom);
            end while (!done16 && lat < 100);
            check("rnd16_res", 128'(r16), 128'(ref_pow(64'(b), 64'(e), 64'(m), 16)));
            check("rnd16_lat", 128'(lat), 128'((m == 16'd0) ? 3 : 35));
            check("rnd16_err", 128'(err16), 128'(m == 16'd0));
        end
    endtask

    task automatic rnd64(input int n);
        logic [63:0] b, e, m;
        int lat;
        for (int i = 0; i < n; i++) begin
            b = {$urandom, $urandom}; e = {$urandom, $urandom}; m = {$urandom, $urandom};
            if (i % 10 == 0) m = 64'($urandom_range(0, 40));
            if (i % 10 == 5) e = 64'($urandom_range(0, 3));
            s64 = 1'b1; b64 = b; e64 = e; m64 = m;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
                s64 = 1'b0; b64 = {$urandom, $urandom}; e64 = {$urandom, $urandom};
                m64 = {$urandom, $urandom};
            end while (!done64 && lat < 300);
            check("rnd64_res", 128'(r64), 128'(ref_pow(b, e, m, 64)));
            check("rnd64_lat", 128'(lat), 128'((m == 64'd0) ? 3 : 131));
            check("rnd64_err", 128'(err64), 128'(m == 64'd0));
        end
    endtask

    initial begin
        int lat;
        int ndone;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_result", 128'(r32),    128'd0);
        check("rst_done",   128'(done32), 128'd0);
        check("rst_busy",   128'(busy32), 128'd0);
        check("rst_err",    128'(err32),  128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic operation and latency
        run32("p3e5m7", 32'd3, 32'd5, 32'd7, 32'd5, 1'b0, 67);

        // Back-to-back: second start in the IDLE cycle right after FIN
        @(negedge clk);
        run32("b2b_a", 32'd5, 32'd6,  32'd23, 32'd8,  1'b0, 67);
        run32("b2b_b", 32'd5, 32'd15, 32'd23, 32'd19, 1'b0, 67);

        // Corner cases
        run32("exp0",  32'd77, 32'd0, 32'd13, 32'd1, 1'b0, 67);
        run32("mod1",  32'd9,  32'd4, 32'd1,  32'd0, 1'b0, 67);
        run32("mod0",  32'd9,  32'd4, 32'd0,  32'd0, 1'b1, 3);
        run32("after0", 32'd2, 32'd3, 32'd11, 32'd8, 1'b0, 67);
        run32("maxexp", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB,
              32'(ref_pow(64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFB, 32)), 1'b0, 67);

        // Start pulsed mid-operation with other operands: ignored, one done
        @(negedge clk);
        s32 = 1'b1; b32 = 32'd7; e32 = 32'd100; m32 = 32'd101;
        lat = 0; ndone = 0;
        repeat (150) begin
            @(negedge clk);
            lat++;
            s32 = (lat == 20);
            if (lat == 20) begin
                b32 = 32'd3; e32 = 32'd5; m32 = 32'd7;
            end
            if (done32) begin
                ndone++;
                if (ndone == 1) begin
                    check("midstart_lat", 128'(lat), 128'd67);
                    check("midstart_res", 128'(r32), 128'd1);
                end
            end
        end
        check("midstart_ndone", 128'(ndone), 128'd1);

        // Reset 10 cycles into an operation: outputs clear, no done
        s32 = 1'b1; b32 = 32'd3; e32 = 32'd5; m32 = 32'd7;
        repeat (10) begin
            @(negedge clk);
            s32 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_result", 128'(r32),    128'd0);
        check("abort_done",   128'(done32), 128'd0);
        check("abort_busy",   128'(busy32), 128'd0);
        check("abort_err",    128'(err32),  128'd0);
        rst = 1'b0;
        ndone = 0;
        repeat (80) begin
            @(negedge clk);
            if (done32) ndone++;
        end
        check("abort_nodone", 128'(ndone), 128'd0);
        run32("p2e10m1000", 32'd2, 32'd10, 32'd1000, 32'd24, 1'b0, 67);

        // Randomised operands against the reference model
        fork
            rnd16(1000);
            rnd64(450);
        join

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
